bank_timing_controller: RTL and testbench



---
 rtl/membridge_timing_pkg.sv | 34 +++
 rtl/max_load_timer.sv | 30 +++
 rtl/bank_timing_controller.sv | 145 ++++++++++++++
 tb/tb_bank_timing_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/membridge_timing_pkg.sv
// Shared command encodings, default timing constants and the load-value clamp
// used by the bank timing controller and its timers.
package membridge_timing_pkg;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    localparam int DEF_NBANKS = 4;
    localparam int DEF_TW     = 6;
    localparam int DEF_T_INIT = 16;
    localparam int DEF_T_RCD  = 3;
    localparam int DEF_T_RP   = 3;
    localparam int DEF_T_RAS  = 8;
    localparam int DEF_T_RC   = 11;
    localparam int DEF_T_WR   = 4;
    localparam int DEF_T_RTP  = 2;
    localparam int DEF_T_RRD  = 2;
    localparam int DEF_T_CCD  = 2;
    localparam int DEF_T_RFC  = 20;

    // A constraint of T cycles loads T-1 (at least 0), saturated to the timer range.
    function automatic int sat_load(input int t, input int tw);
        int v;
        int lim;
        v   = (t > 1) ? t - 1 : 0;
        lim = (tw >= 31) ? 32'h7fff_ffff : (1 << tw) - 1;
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/max_load_timer.sv
// Saturating down-counter; a load never shortens the remaining constraint.
module max_load_timer #(
    parameter int TW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] count;
    logic [TW-1:0] dec;

    // Compare against next cycle's value so an existing constraint keeps its exact end cycle.
    assign dec = (count == '0) ? '0 : count - TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load_en && (load_val > dec)) begin
            count <= load_val;
        end else begin
            count <= dec;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bank_timing_controller.sv
// Multi-bank command timing gate: per-bank and global timers produce legal-command
// masks for the scheduler and a combinational ready for the presented command.
module bank_timing_controller
    import membridge_timing_pkg::*;
#(
    parameter int NBANKS = DEF_NBANKS,
    parameter int TW     = DEF_TW,
    parameter int T_INIT = DEF_T_INIT,
    parameter int T_RCD  = DEF_T_RCD,
    parameter int T_RP   = DEF_T_RP,
    parameter int T_RAS  = DEF_T_RAS,
    parameter int T_RC   = DEF_T_RC,
    parameter int T_WR   = DEF_T_WR,
    parameter int T_RTP  = DEF_T_RTP,
    parameter int T_RRD  = DEF_T_RRD,
    parameter int T_CCD  = DEF_T_CCD,
    parameter int T_RFC  = DEF_T_RFC
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      cmd_valid,
    input  logic [2:0]                cmd_type,
    input  logic [$clog2(NBANKS)-1:0] cmd_bank,
    output logic                      cmd_ready,
    output logic                      init_done,
    output logic [NBANKS-1:0]         act_ok,
    output logic [NBANKS-1:0]         rw_ok,
    output logic [NBANKS-1:0]         pre_ok,
    output logic                      ref_ok
);

    localparam int BW = $clog2(NBANKS);
    localparam int IW = (T_INIT < 1) ? 1 : $clog2(T_INIT + 1);
    localparam logic [IW-1:0] INIT_LOAD = IW'(T_INIT);

    localparam logic [TW-1:0] L_RCD = TW'(sat_load(T_RCD, TW));
    localparam logic [TW-1:0] L_RP  = TW'(sat_load(T_RP,  TW));
    localparam logic [TW-1:0] L_RAS = TW'(sat_load(T_RAS, TW));
    localparam logic [TW-1:0] L_RC  = TW'(sat_load(T_RC,  TW));
    localparam logic [TW-1:0] L_WR  = TW'(sat_load(T_WR,  TW));
    localparam logic [TW-1:0] L_RTP = TW'(sat_load(T_RTP, TW));
    localparam logic [TW-1:0] L_RRD = TW'(sat_load(T_RRD, TW));
    localparam logic [TW-1:0] L_CCD = TW'(sat_load(T_CCD, TW));
    localparam logic [TW-1:0] L_RFC = TW'(sat_load(T_RFC, TW));

    logic [IW-1:0]     init_cnt;
    logic              accept;
    logic              is_act, is_rd, is_wr, is_pre, is_ref;
    logic [TW-1:0]     a_val, p_val;
    logic [NBANKS-1:0] a_zero, rw_zero, p_zero;
    logic              rrd_zero, ccd_zero, rfc_zero;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            init_cnt <= INIT_LOAD;
        end else if (init_cnt != '0) begin
            init_cnt <= init_cnt - IW'(1);
        end
    end

    assign init_done = (init_cnt == '0);

    assign is_act = (cmd_type == CMD_ACT);
    assign is_rd  = (cmd_type == CMD_RD);
    assign is_wr  = (cmd_type == CMD_WR);
    assign is_pre = (cmd_type == CMD_PRE);
    assign is_ref = (cmd_type == CMD_REF);
    assign accept = cmd_valid && cmd_ready;

    // Only one command is accepted per cycle, so one load value per timer kind suffices.
    assign a_val = is_act ? L_RC : L_RP;
    assign p_val = is_act ? L_RAS : (is_wr ? L_WR : L_RTP);

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic hit;
        assign hit = accept && (cmd_bank == BW'(b));

        max_load_timer #(.TW(TW)) u_ta (
            .clk      (sys_clk),
            .rst      (sys_rst),
            .load_en  (hit && (is_act || is_pre)),
            .load_val (a_val),
            .zero     (a_zero[b])
        );

        max_load_timer #(.TW(TW)) u_trw (
            .clk      (sys_clk),
            .rst      (sys_rst),
            .load_en  (hit && is_act),
            .load_val (L_RCD),
            .zero     (rw_zero[b])
        );

        max_load_timer #(.TW(TW)) u_tp (
            .clk      (sys_clk),
            .rst      (sys_rst),
            .load_en  (hit && (is_act || is_rd || is_wr)),
            .load_val (p_val),
            .zero     (p_zero[b])
        );
    end

    max_load_timer #(.TW(TW)) u_grrd (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .load_en  (accept && is_act),
        .load_val (L_RRD),
        .zero     (rrd_zero)
    );

    max_load_timer #(.TW(TW)) u_gccd (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .load_en  (accept && (is_rd || is_wr)),
        .load_val (L_CCD),
        .zero     (ccd_zero)
    );

    max_load_timer #(.TW(TW)) u_grfc (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .load_en  (accept && is_ref),
        .load_val (L_RFC),
        .zero     (rfc_zero)
    );

    assign act_ok = init_done ? (a_zero & {NBANKS{rrd_zero && rfc_zero}}) : '0;
    assign rw_ok  = init_done ? (rw_zero & {NBANKS{ccd_zero}}) : '0;
    assign pre_ok = init_done ? p_zero : '0;
    assign ref_ok = init_done && (&a_zero) && rfc_zero;

    always_comb begin
        cmd_ready = 1'b0;
        case (cmd_type)
            CMD_NOP: cmd_ready = init_done;
            CMD_ACT: cmd_ready = act_ok[cmd_bank];
            CMD_RD,
            CMD_WR:  cmd_ready = rw_ok[cmd_bank];
            CMD_PRE: cmd_ready = pre_ok[cmd_bank];
            CMD_REF: cmd_ready = ref_ok;
            default: cmd_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_bank_timing_controller.sv
// Directed bench for bank_timing_controller: init hold, a cycle-by-cycle command
// table with hand-computed masks, and sequences for tRAS max-load, tRFC and mid-run reset.
module tb_bank_timing_controller;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_type = 3'd0;
    logic [1:0] cmd_bank = 2'd0;
    logic       cmd_ready;
    logic       init_done;
    logic [3:0] act_ok, rw_ok, pre_ok;
    logic       ref_ok;

    int errors = 0;
    int checks = 0;

    bank_timing_controller dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_type  (cmd_type),
        .cmd_bank  (cmd_bank),
        .cmd_ready (cmd_ready),
        .init_done (init_done),
        .act_ok    (act_ok),
        .rw_ok     (rw_ok),
        .pre_ok    (pre_ok),
        .ref_ok    (ref_ok)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic       valid;
        logic [2:0] typ;
        logic [1:0] bank;
        logic       rdy;
        logic [3:0] act;
        logic [3:0] rw;
        logic [3:0] pre;
        logic       rf;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic present(input logic v, input logic [2:0] t, input logic [1:0] b);
        cmd_valid = v;
        cmd_type  = t;
        cmd_bank  = b;
    endtask

    task automatic do_reset_and_init();
        present(1'b0, 3'd0, 2'd0);
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        for (int i = 0; i < 16; i++) tick();
    endtask

    initial begin
        //            valid  type  bank  rdy   act      rw       pre      ref
        vecs[0]  = '{1'b1, 3'd1, 2'd0, 1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b1}; // ACT b0
        vecs[1]  = '{1'b1, 3'd1, 2'd1, 1'b0, 4'b0000, 4'b1110, 4'b1110, 1'b0}; // ACT b1 blocked by tRRD
        vecs[2]  = '{1'b1, 3'd1, 2'd1, 1'b1, 4'b1110, 4'b1110, 4'b1110, 1'b0}; // ACT b1
        vecs[3]  = '{1'b1, 3'd2, 2'd0, 1'b1, 4'b0000, 4'b1101, 4'b1100, 1'b0}; // RD b0 at tRCD
        vecs[4]  = '{1'b1, 3'd2, 2'd0, 1'b0, 4'b1100, 4'b0000, 4'b1100, 1'b0}; // RD b0 blocked by tCCD
        vecs[5]  = '{1'b1, 3'd3, 2'd0, 1'b1, 4'b1100, 4'b1111, 4'b1100, 1'b0}; // WR b0
        vecs[6]  = '{1'b1, 3'd4, 2'd0, 1'b0, 4'b1100, 4'b0000, 4'b1100, 1'b0}; // PRE b0 blocked
        vecs[7]  = '{1'b1, 3'd0, 2'd0, 1'b1, 4'b1100, 4'b1111, 4'b1100, 1'b0}; // NOP
        vecs[8]  = '{1'b1, 3'd6, 2'd0, 1'b0, 4'b1100, 4'b1111, 4'b1100, 1'b0}; // reserved
        vecs[9]  = '{1'b1, 3'd4, 2'd0, 1'b1, 4'b1100, 4'b1111, 4'b1101, 1'b0}; // PRE b0 (tRAS met)
        vecs[10] = '{1'b1, 3'd1, 2'd0, 1'b0, 4'b1100, 4'b1111, 4'b1111, 1'b0}; // ACT b0 blocked by tRP
        vecs[11] = '{1'b1, 3'd1, 2'd0, 1'b0, 4'b1100, 4'b1111, 4'b1111, 1'b0};
        vecs[12] = '{1'b1, 3'd1, 2'd0, 1'b1, 4'b1101, 4'b1111, 4'b1111, 1'b0}; // ACT b0
        vecs[13] = '{1'b1, 3'd5, 2'd0, 1'b0, 4'b0000, 4'b1110, 4'b1110, 1'b0}; // REF blocked
        vecs[14] = '{1'b0, 3'd1, 2'd3, 1'b1, 4'b1110, 4'b1110, 4'b1110, 1'b0}; // ACT b3 not valid
        vecs[15] = '{1'b1, 3'd1, 2'd3, 1'b1, 4'b1110, 4'b1111, 4'b1110, 1'b0}; // ACT b3, no tRRD residue

        // Init hold with a NOP continuously presented.
        present(1'b1, 3'd0, 2'd0);
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        chk("reset_act_ok", 32'(act_ok), 32'h0);
        chk("reset_rw_ok", 32'(rw_ok), 32'h0);
        chk("reset_pre_ok", 32'(pre_ok), 32'h0);
        chk("reset_ref_ok", 32'(ref_ok), 32'h0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("init_done_c%0d", i), 32'(init_done), 32'h0);
            chk($sformatf("init_ready_c%0d", i), 32'(cmd_ready), 32'h0);
            tick();
        end
        chk("init_done_c16", 32'(init_done), 32'h1);
        chk("init_act_ok", 32'(act_ok), 32'hf);
        chk("init_rw_ok", 32'(rw_ok), 32'hf);
        chk("init_pre_ok", 32'(pre_ok), 32'hf);
        chk("init_ref_ok", 32'(ref_ok), 32'h1);
        chk("init_nop_ready", 32'(cmd_ready), 32'h1);

        for (int i = 0; i < 16; i++) begin
            present(vecs[i].valid, vecs[i].typ, vecs[i].bank);
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'(vecs[i].rdy));
            chk($sformatf("vec%0d_act_ok", i), 32'(act_ok), 32'(vecs[i].act));
            chk($sformatf("vec%0d_rw_ok", i), 32'(rw_ok), 32'(vecs[i].rw));
            chk($sformatf("vec%0d_pre_ok", i), 32'(pre_ok), 32'(vecs[i].pre));
            chk($sformatf("vec%0d_ref_ok", i), 32'(ref_ok), 32'(vecs[i].rf));
            tick();
        end

        // tRAS outlasts tRTP: RD three cycles after ACT must not release PRE early.
        do_reset_and_init();
        present(1'b1, 3'd1, 2'd2);
        chk("ml_act_ready", 32'(cmd_ready), 32'h1);
        tick();
        present(1'b0, 3'd0, 2'd0);
        tick();
        tick();
        present(1'b1, 3'd2, 2'd2);
        chk("ml_rd_ready", 32'(cmd_ready), 32'h1);
        tick();
        present(1'b0, 3'd0, 2'd0);
        for (int k = 4; k <= 8; k++) begin
            chk($sformatf("ml_pre_ok2_c%0d", k), 32'(pre_ok[2]), (k == 8) ? 32'h1 : 32'h0);
            tick();
        end

        // tRFC blocks every ACT and REF for 20 cycles.
        do_reset_and_init();
        present(1'b1, 3'd5, 2'd0);
        chk("rfc_ref_ready", 32'(cmd_ready), 32'h1);
        tick();
        present(1'b0, 3'd0, 2'd0);
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("rfc_act_ok_c%0d", k), 32'(act_ok), (k == 20) ? 32'hf : 32'h0);
            chk($sformatf("rfc_ref_ok_c%0d", k), 32'(ref_ok), (k == 20) ? 32'h1 : 32'h0);
            tick();
        end

        // Reset in the middle of tRAS restarts the init hold and drops all constraints.
        do_reset_and_init();
        present(1'b1, 3'd1, 2'd0);
        chk("mr_act_ready", 32'(cmd_ready), 32'h1);
        tick();
        present(1'b0, 3'd0, 2'd0);
        for (int k = 1; k < 5; k++) tick();
        chk("mr_pre_ok_before", 32'(pre_ok), 32'he);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("mr_init_done_c0", 32'(init_done), 32'h0);
        chk("mr_act_ok_c0", 32'(act_ok), 32'h0);
        for (int k = 0; k < 15; k++) tick();
        chk("mr_init_done_c15", 32'(init_done), 32'h0);
        tick();
        chk("mr_init_done_c16", 32'(init_done), 32'h1);
        chk("mr_act_ok", 32'(act_ok), 32'hf);
        chk("mr_rw_ok", 32'(rw_ok), 32'hf);
        chk("mr_pre_ok", 32'(pre_ok), 32'hf);
        chk("mr_ref_ok", 32'(ref_ok), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
